// File: rtl/morse_timing_classifier.sv
// Morse key timing classifier.
// Measures key press/gap run lengths, learns a dot/dash threshold from a
// four-dot / four-dash calibration sequence, then classifies presses into
// dots and dashes and flags inter-letter gaps.
module morse_timing_classifier #(
  parameter int CNT_W = 16
) (
  input  logic             ClkPort,
  input  logic             Reset_n,
  input  logic             key,
  input  logic             cal_en,
  input  logic             dec_en,
  output logic             sym_valid,
  output logic             sym_dash,
  output logic             letter_end,
  output logic             cal_done,
  output logic             cal_err,
  output logic [CNT_W-1:0] threshold,
  output logic [2:0]       state
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] L_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAL_DOT  = 3'd1,
    ST_CAL_DASH = 3'd2,
    ST_CALC     = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             key_q;
  logic [CNT_W-1:0] run_len_q;
  logic [SUM_W-1:0] dot_sum_q, dot_sum_d;
  logic [SUM_W-1:0] dash_sum_q, dash_sum_d;
  logic [1:0]       press_cnt_q, press_cnt_d;
  logic [CNT_W-1:0] thr_q, thr_d;
  logic             cal_done_q, cal_done_d;
  logic             cal_err_q, cal_err_d;
  logic             sym_valid_q, sym_dash_q;
  logic             pending_q;

  logic             release_w;
  logic [SUM_W-1:0] press_ext_w;
  logic [SUM_W-1:0] dot_avg_w, dash_avg_w;
  logic [CNT_W:0]   thr_plus1_w;
  logic             letter_end_w;

  // A release is seen on the edge where key_q falls; run_len_q then still
  // holds the number of cycles key_q was high.
  assign release_w   = key_q & ~key;
  assign press_ext_w = {2'b00, run_len_q};
  assign dot_avg_w   = dot_sum_q >> 2;
  assign dash_avg_w  = dash_sum_q >> 2;
  assign thr_plus1_w = {1'b0, thr_q} + (CNT_W + 1)'(1);

  // Key register and saturating run-length counter of the current key_q level.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      key_q     <= 1'b0;
      run_len_q <= '0;
    end else begin
      key_q <= key;
      if (key != key_q) begin
        run_len_q <= CNT_W'(1);
      end else if (run_len_q != L_MAX) begin
        run_len_q <= run_len_q + CNT_W'(1);
      end
    end
  end

  // Next-state and calibration datapath for the mode FSM.
  // NOTE: every always_comb target gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    dot_sum_d   = dot_sum_q;
    dash_sum_d  = dash_sum_q;
    press_cnt_d = press_cnt_q;
    thr_d       = thr_q;
    cal_done_d  = cal_done_q;
    cal_err_d   = cal_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cal_en) begin
          state_d     = ST_CAL_DOT;
          dot_sum_d   = '0;
          dash_sum_d  = '0;
          press_cnt_d = '0;
          cal_err_d   = 1'b0;
        end else if (dec_en && cal_done_q) begin
          state_d = ST_RUN;
        end
      end
      ST_CAL_DOT: begin
        if (!cal_en) begin
          state_d = ST_IDLE;
        end else if (release_w) begin
          dot_sum_d = dot_sum_q + press_ext_w;
          if (press_cnt_q == 2'd3) begin
            state_d     = ST_CAL_DASH;
            press_cnt_d = '0;
          end else begin
            press_cnt_d = press_cnt_q + 2'd1;
          end
        end
      end
      ST_CAL_DASH: begin
        if (!cal_en) begin
          state_d = ST_IDLE;
        end else if (release_w) begin
          dash_sum_d = dash_sum_q + press_ext_w;
          if (press_cnt_q == 2'd3) begin
            state_d     = ST_CALC;
            press_cnt_d = '0;
          end else begin
            press_cnt_d = press_cnt_q + 2'd1;
          end
        end
      end
      ST_CALC: begin
        state_d = ST_IDLE;
        if (dash_avg_w > dot_avg_w) begin
          thr_d      = CNT_W'(({1'b0, dot_avg_w} + {1'b0, dash_avg_w}) >> 1);
          cal_done_d = 1'b1;
          cal_err_d  = 1'b0;
        end else begin
          cal_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (cal_en || !dec_en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and calibration registers.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      dot_sum_q   <= '0;
      dash_sum_q  <= '0;
      press_cnt_q <= '0;
      thr_q       <= '0;
      cal_done_q  <= 1'b0;
      cal_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dot_sum_q   <= dot_sum_d;
      dash_sum_q  <= dash_sum_d;
      press_cnt_q <= press_cnt_d;
      thr_q       <= thr_d;
      cal_done_q  <= cal_done_d;
      cal_err_q   <= cal_err_d;
    end
  end

  // Symbol strobe in the cycle after a release, and the letter-pending flag
  // that arms one letter_end per gap after at least one symbol.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      sym_valid_q <= 1'b0;
      sym_dash_q  <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      sym_valid_q <= (state_q == ST_RUN) && release_w;
      sym_dash_q  <= (state_q == ST_RUN) && release_w && (run_len_q > thr_q);
      if (state_q != ST_RUN || letter_end_w) begin
        pending_q <= 1'b0;
      end else if (sym_valid_q) begin
        pending_q <= 1'b1;
      end
    end
  end

  // letter_end fires in the gap cycle whose run length equals threshold+1;
  // the run length only passes that value once per gap.
  assign letter_end_w = (state_q == ST_RUN) && !key_q && pending_q && !sym_valid_q &&
                        ({1'b0, run_len_q} == thr_plus1_w);

  assign sym_valid  = sym_valid_q;
  assign sym_dash   = sym_dash_q;
  assign letter_end = letter_end_w;
  assign cal_done   = cal_done_q;
  assign cal_err    = cal_err_q;
  assign threshold  = thr_q;
  assign state      = state_q;

endmodule

// File: tb/tb_morse_timing_classifier.sv
// Directed testbench for morse_timing_classifier.
module tb_morse_timing_classifier;

  logic        clk;
  logic        rst_n;
  logic        key, cal_en, dec_en;
  logic        sym_valid, sym_dash, letter_end, cal_done, cal_err;
  logic [15:0] threshold;
  logic [2:0]  state;

  int n_checks = 0;
  int n_pass   = 0;

  morse_timing_classifier #(.CNT_W(16)) dut (
    .ClkPort   (clk),
    .Reset_n   (rst_n),
    .key       (key),
    .cal_en    (cal_en),
    .dec_en    (dec_en),
    .sym_valid (sym_valid),
    .sym_dash  (sym_dash),
    .letter_end(letter_end),
    .cal_done  (cal_done),
    .cal_err   (cal_err),
    .threshold (threshold),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one clock; inputs set after this are seen at the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    key = 1'b1;
    repeat (hi) cyc();
    key = 1'b0;
    repeat (lo) cyc();
  endtask

  // Full calibration; cal_en is dropped during the single CALC cycle.
  task automatic calibrate(input int dot_p, input int dash_p, input string tag);
    cal_en = 1'b1;
    cyc();
    cyc();
    check({tag, "_in_cal_dot"}, state, 1);
    for (int i = 0; i < 4; i++) press(dot_p, dot_p);
    check({tag, "_in_cal_dash"}, state, 2);
    for (int i = 0; i < 3; i++) press(dash_p, dash_p);
    key = 1'b1;
    repeat (dash_p) cyc();
    key = 1'b0;
    cyc();
    check({tag, "_calc"}, state, 3);
    cal_en = 1'b0;
    cyc();
    check({tag, "_idle"}, state, 0);
  endtask

  // Press in RUN and check the resulting symbol strobe.
  task automatic run_sym(input int hi, input logic exp_dash, input string tag);
    key = 1'b1;
    repeat (hi) cyc();
    key = 1'b0;
    cyc();
    check({tag, "_valid"}, sym_valid, 1);
    check({tag, "_dash"}, sym_dash, exp_dash);
    cyc();
    check({tag, "_valid_off"}, sym_valid, 0);
  endtask

  initial begin
    int first_le;
    int le_count;
    int overlap;

    rst_n = 1'b0; key = 1'b0; cal_en = 1'b0; dec_en = 1'b0;
    #2;
    check("rst_state", state, 0);
    check("rst_outs", {sym_valid, sym_dash, letter_end, cal_done, cal_err}, 0);
    check("rst_thr", threshold, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();

    // Rejected calibration with no prior threshold; RUN entry stays blocked.
    calibrate(5, 5, "rej0");
    check("rej0_err", cal_err, 1);
    check("rej0_done", cal_done, 0);
    check("rej0_thr", threshold, 0);
    dec_en = 1'b1;
    repeat (3) cyc();
    check("run_blocked", state, 0);
    dec_en = 1'b0;
    cyc();

    // Good calibration: dots 2, dashes 20 -> threshold (2+20)/2 = 11.
    calibrate(2, 20, "cal");
    check("cal_thr", threshold, 11);
    check("cal_done", cal_done, 1);
    check("cal_err", cal_err, 0);

    // Decode "A".
    dec_en = 1'b1;
    cyc();
    check("run_entry", state, 4);
    run_sym(2, 1'b0, "a_dot");
    run_sym(20, 1'b1, "a_dash");
    first_le = -1; le_count = 0; overlap = 0;
    for (int k = 3; k <= 40; k++) begin
      cyc();
      if (letter_end) begin
        le_count++;
        if (first_le < 0) first_le = k;
        if (sym_valid) overlap++;
      end
    end
    check("a_le_time", first_le, 12);
    check("a_le_count", le_count, 1);
    check("a_le_overlap", overlap, 0);

    // Threshold boundary.
    run_sym(11, 1'b0, "p11");
    repeat (20) cyc();
    run_sym(12, 1'b1, "p12");
    repeat (20) cyc();

    // Saturating run length on a very long press.
    key = 1'b1;
    repeat (70000) cyc();
    check("sat_len", dut.run_len_q, 65535);
    key = 1'b0;
    cyc();
    check("sat_valid", sym_valid, 1);
    check("sat_dash", sym_dash, 1);
    repeat (20) cyc();

    dec_en = 1'b0;
    cyc();
    check("run_exit", state, 0);

    // Rejected calibration keeps the earlier threshold.
    calibrate(5, 5, "rej1");
    check("rej1_err", cal_err, 1);
    check("rej1_done", cal_done, 1);
    check("rej1_thr", threshold, 11);

    // Abort after the second dash press.
    cal_en = 1'b1;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++) press(2, 2);
    for (int i = 0; i < 2; i++) press(20, 20);
    check("abort_pre", state, 2);
    cal_en = 1'b0;
    cyc();
    check("abort_state", state, 0);
    check("abort_thr", threshold, 11);
    check("abort_done", cal_done, 1);

    // Asynchronous reset during CAL_DOT, then a full recalibration.
    cal_en = 1'b1;
    cyc();
    cyc();
    check("rst2_in_dot", state, 1);
    press(4, 4);
    press(4, 4);
    #3 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_outs", {sym_valid, sym_dash, letter_end, cal_done, cal_err}, 0);
    check("arst_thr", threshold, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check("recal_dot", state, 1);
    for (int i = 0; i < 4; i++) press(4, 4);
    for (int i = 0; i < 3; i++) press(12, 12);
    check("recal_7_state", state, 2);
    check("recal_7_done", cal_done, 0);
    key = 1'b1;
    repeat (12) cyc();
    key = 1'b0;
    cyc();
    check("recal_calc", state, 3);
    cal_en = 1'b0;
    cyc();
    check("recal_thr", threshold, 8);
    check("recal_done", cal_done, 1);
    check("recal_idle", state, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
